// File: rtl/gmii_frame_rx_if.sv
// Byte/valid receive stream and the decoded frame outputs of gmii_frame_rx.
// The slave modport is the receiver; the master modport is whoever feeds it and consumes its results.
interface gmii_frame_rx_if #(
    parameter int LEN_W = 16
);
    logic [7:0]       rxd;
    logic             rx_dv;
    logic [7:0]       dout;
    logic             dout_vld;
    logic             dout_sof;
    logic             dout_eof;
    logic             frm_done;
    logic [1:0]       frm_err;
    logic [LEN_W-1:0] frm_len;
    logic [7:0]       err_cnt;

    modport master (
        output rxd, rx_dv,
        input  dout, dout_vld, dout_sof, dout_eof, frm_done, frm_err, frm_len, err_cnt
    );

    modport slave (
        input  rxd, rx_dv,
        output dout, dout_vld, dout_sof, dout_eof, frm_done, frm_err, frm_len, err_cnt
    );
endinterface

// File: rtl/gmii_frame_rx.sv
// Strips preamble/SFD from a byte/valid stream and re-emits the payload with sof/eof marks.
// It also reports per-frame status, length and a saturating count of bad frames.
//
// state  | meaning
// S_IDLE | waiting for a rising edge of rx_dv
// S_PRE  | counting 0x55 preamble bytes, looking for the SFD
// S_DATA | payload: one byte held back so the last one can be flagged eof
// S_DROP | discarding the rest of a bad or overlong frame until rx_dv falls
module gmii_frame_rx #(
    parameter int PRE_MIN = 7,
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    gmii_frame_rx_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

    localparam logic [7:0]       PRE_BYTE = 8'h55;
    localparam logic [7:0]       SFD_BYTE = 8'hD5;
    localparam logic [3:0]       PRE_THR  = 4'(PRE_MIN);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_dv_d;
    logic [3:0]       r_pre_cnt;
    logic [7:0]       r_hold;
    logic [LEN_W-1:0] r_len;
    logic [7:0]       r_sum;
    logic             r_drop_done;
    logic [7:0]       r_dout;
    logic             r_vld;
    logic             r_sof;
    logic             r_eof;
    logic             r_done;
    logic [1:0]       r_err;
    logic [LEN_W-1:0] r_flen;
    logic [7:0]       r_err_cnt;

    logic             w_start;
    logic             w_is_pre;
    logic             w_is_sfd;
    logic             w_len_full;
    logic             w_emit;
    logic             w_sof;
    logic             w_eof;
    logic             w_done;
    logic [1:0]       w_err;
    logic [LEN_W-1:0] w_flen;

    // r_dv_d resets high so a frame already running at reset exit is never taken as a start.
    assign w_start    = bus.rx_dv & ~r_dv_d;
    assign w_is_pre   = (bus.rxd == PRE_BYTE);
    assign w_is_sfd   = (bus.rxd == SFD_BYTE);
    assign w_len_full = (r_len == LEN_MAX);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = w_is_pre ? S_PRE : S_DROP;
                end
            end
            S_PRE: begin
                if (!bus.rx_dv) begin
                    w_state_nxt = S_IDLE;
                end else if (w_is_sfd && (r_pre_cnt >= PRE_THR)) begin
                    w_state_nxt = S_DATA;
                end else if (!w_is_pre) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DATA: begin
                if (!bus.rx_dv) begin
                    w_state_nxt = S_IDLE;
                end else if (w_len_full) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (!bus.rx_dv) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_emit = 1'b0;
        w_sof  = 1'b0;
        w_eof  = 1'b0;
        w_done = 1'b0;
        w_err  = 2'd0;
        w_flen = '0;
        case (r_state)
            S_PRE: begin
                if (!bus.rx_dv) begin
                    w_done = 1'b1;
                    w_err  = 2'd1;
                end
            end
            S_DATA: begin
                if (!bus.rx_dv || w_len_full) begin
                    w_emit = (r_len != '0);
                    w_sof  = (r_len == LEN_W'(1));
                    w_eof  = (r_len != '0);
                    w_done = 1'b1;
                    w_flen = r_len;
                    // The held byte is the checksum of everything emitted before it.
                    if (bus.rx_dv || (r_len < LEN_W'(2))) begin
                        w_err = 2'd3;
                    end else if (r_hold != r_sum) begin
                        w_err = 2'd2;
                    end
                end else if (r_len != '0) begin
                    w_emit = 1'b1;
                    w_sof  = (r_len == LEN_W'(1));
                end
            end
            S_DROP: begin
                if (!bus.rx_dv && r_drop_done) begin
                    w_done = 1'b1;
                    w_err  = 2'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dv_d      <= 1'b1;
            r_pre_cnt   <= '0;
            r_hold      <= '0;
            r_len       <= '0;
            r_sum       <= '0;
            r_drop_done <= 1'b0;
            r_dout      <= '0;
            r_vld       <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= '0;
            r_flen      <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_dv_d <= bus.rx_dv;
            r_vld  <= w_emit;
            r_sof  <= w_sof;
            r_eof  <= w_eof;
            r_done <= w_done;
            if (w_emit) begin
                r_dout <= r_hold;
            end
            if (w_done) begin
                r_err  <= w_err;
                r_flen <= w_flen;
                if ((w_err != 2'd0) && (r_err_cnt != 8'hFF)) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_pre_cnt   <= 4'd1;
                        r_len       <= '0;
                        r_sum       <= '0;
                        r_drop_done <= 1'b1;
                    end
                end
                S_PRE: begin
                    if (bus.rx_dv && w_is_pre && (r_pre_cnt != 4'hF)) begin
                        r_pre_cnt <= r_pre_cnt + 4'd1;
                    end
                end
                S_DATA: begin
                    if (bus.rx_dv) begin
                        if (w_len_full) begin
                            r_drop_done <= 1'b0;
                        end else begin
                            r_hold <= bus.rxd;
                            r_len  <= r_len + LEN_W'(1);
                            if (r_len != '0) begin
                                r_sum <= r_sum + r_hold;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dout     = r_dout;
    assign bus.dout_vld = r_vld;
    assign bus.dout_sof = r_sof;
    assign bus.dout_eof = r_eof;
    assign bus.frm_done = r_done;
    assign bus.frm_err  = r_err;
    assign bus.frm_len  = r_flen;
    assign bus.err_cnt  = r_err_cnt;
endmodule

// File: tb/tb_gmii_frame_rx.sv
// Bench for gmii_frame_rx: two instances (default and MAX_LEN=4) share one stimulus stream that is
// checked every cycle against a frame-level reference model, plus hand-computed literals.
module tb_gmii_frame_rx;
    localparam int NMAX    = 16384;
    localparam int PRE_MIN = 7;

    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    gmii_frame_rx_if #(.LEN_W(16)) bus0 ();
    gmii_frame_rx_if #(.LEN_W(16)) bus1 ();

    gmii_frame_rx #(.PRE_MIN(7), .MAX_LEN(1518), .LEN_W(16)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus0)
    );
    gmii_frame_rx #(.PRE_MIN(7), .MAX_LEN(4), .LEN_W(16)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus1)
    );

    // stimulus, one entry per rising edge
    bit         s_rst [NMAX];
    bit         s_dv  [NMAX];
    logic [7:0] s_d   [NMAX];
    int         n_cyc = 0;

    // expected outputs after each edge, per instance
    bit         e_vld  [2][NMAX];
    bit         e_sof  [2][NMAX];
    bit         e_eof  [2][NMAX];
    logic [7:0] e_dout [2][NMAX];
    bit         e_done [2][NMAX];
    int         e_err  [2][NMAX];
    int         e_len  [2][NMAX];
    int         e_cnt  [2][NMAX];

    // hand-computed frame-status literals
    int lit_t[$];
    int lit_p[$];
    int lit_err[$];
    int lit_len[$];
    int lit_cnt[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit running = 1'b0;

    task automatic push(input bit r, input bit v, input logic [7:0] d);
        if (n_cyc < NMAX) begin
            s_rst[n_cyc] = r;
            s_dv[n_cyc]  = v;
            s_d[n_cyc]   = d;
            n_cyc++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) push(1'b1, 1'b0, 8'h00);
    endtask

    task automatic pre(input int n);
        repeat (n) push(1'b1, 1'b1, 8'h55);
    endtask

    task automatic lit(input int p, input int err, input int len, input int cnt);
        lit_t.push_back(n_cyc);
        lit_p.push_back(p);
        lit_err.push_back(err);
        lit_len.push_back(len);
        lit_cnt.push_back(cnt);
    endtask

    task automatic rand_frame();
        int         kind;
        int         np;
        int         nd;
        logic [7:0] sum;
        logic [7:0] b;
        kind = $urandom_range(0, 19);
        np   = (kind == 0) ? $urandom_range(0, 6) : $urandom_range(7, 18);
        pre(np);
        if (kind == 1) push(1'b1, 1'b1, 8'($urandom_range(0, 255)));
        else if (kind != 2) push(1'b1, 1'b1, 8'hD5);
        nd  = $urandom_range(0, 8);
        sum = 8'h00;
        for (int i = 0; i < nd; i++) begin
            if (kind == 3 && i == nd / 2) push(1'b0, 1'b1, 8'h00);
            b = 8'($urandom_range(0, 255));
            if (i == nd - 1 && kind != 4) b = sum;
            push(1'b1, 1'b1, b);
            sum += b;
        end
        repeat ($urandom_range(1, 3)) push(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    endtask

    task automatic emit_at(input int p, input int t, input logic [7:0] d, input bit sof, input bit eof);
        e_vld[p][t]  = 1'b1;
        e_dout[p][t] = d;
        e_sof[p][t]  = sof;
        e_eof[p][t]  = eof;
    endtask

    task automatic done_at(input int p, input int t, input int err, input int len);
        e_done[p][t] = 1'b1;
        e_err[p][t]  = err;
        e_len[p][t]  = len;
    endtask

    // Frame-level model: cut the stream into frames, classify each, place its outputs.
    task automatic run_model(input int p, input int maxlen);
        logic [7:0] fb[$];
        int         fe[$];
        bit         prev_dv;
        bit         aborted;
        int         t, k, n, np, ds, nd;
        int         herr, hlen, cnt;
        logic [7:0] sum;
        for (int i = 0; i < NMAX; i++) begin
            e_vld[p][i] = 1'b0; e_sof[p][i] = 1'b0; e_eof[p][i] = 1'b0; e_dout[p][i] = 8'h00;
            e_done[p][i] = 1'b0; e_err[p][i] = 0; e_len[p][i] = 0; e_cnt[p][i] = 0;
        end
        prev_dv = 1'b1;
        t = 0;
        while (t < n_cyc) begin
            if (s_rst[t] && s_dv[t] && !prev_dv) begin
                fb.delete();
                fe.delete();
                k = t;
                while (k < n_cyc && s_rst[k] && s_dv[k]) begin
                    fb.push_back(s_d[k]);
                    fe.push_back(k);
                    k++;
                end
                aborted = (k >= n_cyc) || !s_rst[k];
                n  = fb.size();
                np = 0;
                while (np < n && fb[np] == 8'h55) np++;
                if (np == 0 || np >= n || fb[np] != 8'hD5 || np < PRE_MIN) begin
                    if (!aborted) done_at(p, k, 1, 0);
                end else begin
                    ds = np + 1;
                    nd = n - ds;
                    if (nd > maxlen) begin
                        for (int i = 0; i < maxlen; i++)
                            emit_at(p, fe[ds+i+1], fb[ds+i], i == 0, i == maxlen - 1);
                        done_at(p, fe[ds+maxlen], 3, maxlen);
                    end else begin
                        for (int i = 0; i < nd - 1; i++)
                            emit_at(p, fe[ds+i+1], fb[ds+i], i == 0, 1'b0);
                        if (!aborted) begin
                            if (nd == 0) begin
                                done_at(p, k, 3, 0);
                            end else begin
                                sum = 8'h00;
                                for (int i = 0; i < nd - 1; i++) sum += fb[ds+i];
                                emit_at(p, k, fb[n-1], nd == 1, 1'b1);
                                done_at(p, k, (nd < 2) ? 3 : ((fb[n-1] == sum) ? 0 : 2), nd);
                            end
                        end
                    end
                end
                t = k;
                continue;
            end
            prev_dv = s_rst[t] ? s_dv[t] : 1'b1;
            t++;
        end
        herr = 0; hlen = 0; cnt = 0;
        for (int i = 0; i < n_cyc; i++) begin
            if (!s_rst[i]) begin
                herr = 0; hlen = 0; cnt = 0;
            end else if (e_done[p][i]) begin
                herr = e_err[p][i];
                hlen = e_len[p][i];
                if (herr != 0 && cnt < 255) cnt++;
            end
            e_err[p][i] = herr;
            e_len[p][i] = hlen;
            e_cnt[p][i] = cnt;
        end
    endtask

    task automatic cmp(input string nm, input int p, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d edge %0d: got %0h expected %0h", nm, p, cyc, act, exp);
        end
    endtask

    task automatic chk_inst(input int p, input logic vld, input logic sof, input logic eof,
                            input logic [7:0] d, input logic done, input logic [1:0] err,
                            input logic [15:0] len, input logic [7:0] cnt);
        cmp("dout_vld", p, 32'(vld), 32'(e_vld[p][cyc]));
        if (e_vld[p][cyc]) begin
            cmp("dout", p, 32'(d), 32'(e_dout[p][cyc]));
            cmp("dout_sof", p, 32'(sof), 32'(e_sof[p][cyc]));
            cmp("dout_eof", p, 32'(eof), 32'(e_eof[p][cyc]));
        end
        cmp("frm_done", p, 32'(done), 32'(e_done[p][cyc]));
        cmp("frm_err", p, 32'(err), 32'(e_err[p][cyc]));
        cmp("frm_len", p, 32'(len), 32'(e_len[p][cyc]));
        cmp("err_cnt", p, 32'(cnt), 32'(e_cnt[p][cyc]));
        for (int i = 0; i < lit_t.size(); i++) begin
            if (lit_t[i] == cyc && lit_p[i] == p) begin
                cmp("lit_done", p, 32'(done), 32'd1);
                cmp("lit_err", p, 32'(err), 32'(lit_err[i]));
                cmp("lit_len", p, 32'(len), 32'(lit_len[i]));
                cmp("lit_cnt", p, 32'(cnt), 32'(lit_cnt[i]));
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (running) begin
                chk_inst(0, bus0.dout_vld, bus0.dout_sof, bus0.dout_eof, bus0.dout,
                         bus0.frm_done, bus0.frm_err, bus0.frm_len, bus0.err_cnt);
                chk_inst(1, bus1.dout_vld, bus1.dout_sof, bus1.dout_eof, bus1.dout,
                         bus1.frm_done, bus1.frm_err, bus1.frm_len, bus1.err_cnt);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus0.rxd = 8'h00; bus0.rx_dv = 1'b0;
        bus1.rxd = 8'h00; bus1.rx_dv = 1'b0;

        repeat (3) push(1'b0, 1'b0, 8'h00);
        idle(2);
        // good frame
        pre(7); push(1'b1, 1'b1, 8'hD5);
        push(1'b1, 1'b1, 8'h01); push(1'b1, 1'b1, 8'h02); push(1'b1, 1'b1, 8'h03); push(1'b1, 1'b1, 8'h06);
        lit(0, 0, 4, 0); lit(1, 0, 4, 0);
        idle(1);
        // bad checksum
        pre(7); push(1'b1, 1'b1, 8'hD5);
        push(1'b1, 1'b1, 8'h01); push(1'b1, 1'b1, 8'h02); push(1'b1, 1'b1, 8'h03); push(1'b1, 1'b1, 8'h07);
        lit(0, 2, 4, 1); lit(1, 2, 4, 1);
        idle(1);
        // short preamble
        pre(5); push(1'b1, 1'b1, 8'hD5); push(1'b1, 1'b1, 8'h01); push(1'b1, 1'b1, 8'h01);
        lit(0, 1, 0, 2); lit(1, 1, 0, 2);
        idle(1);
        // empty payload, then single byte
        pre(7); push(1'b1, 1'b1, 8'hD5);
        lit(0, 3, 0, 3); lit(1, 3, 0, 3);
        idle(1);
        pre(7); push(1'b1, 1'b1, 8'hD5); push(1'b1, 1'b1, 8'hAA);
        lit(0, 3, 1, 4); lit(1, 3, 1, 4);
        idle(1);
        // overflow on the MAX_LEN=4 instance, clean 6-byte frame on the default one
        pre(7); push(1'b1, 1'b1, 8'hD5);
        push(1'b1, 1'b1, 8'h01); push(1'b1, 1'b1, 8'h02); push(1'b1, 1'b1, 8'h03); push(1'b1, 1'b1, 8'h04);
        lit(1, 3, 4, 5);
        push(1'b1, 1'b1, 8'h05); push(1'b1, 1'b1, 8'h0F);
        lit(0, 0, 6, 4);
        idle(1);
        // reset mid-payload with rx_dv held high
        pre(7); push(1'b1, 1'b1, 8'hD5); push(1'b1, 1'b1, 8'h01); push(1'b1, 1'b1, 8'h02);
        push(1'b0, 1'b1, 8'h03); push(1'b1, 1'b1, 8'h04); push(1'b1, 1'b1, 8'h05);
        idle(1);
        pre(7); push(1'b1, 1'b1, 8'hD5);
        push(1'b1, 1'b1, 8'h0A); push(1'b1, 1'b1, 8'h0B); push(1'b1, 1'b1, 8'h15);
        lit(0, 0, 3, 0); lit(1, 0, 3, 0);
        idle(1);
        // error counter saturation
        for (int i = 0; i < 256; i++) begin
            push(1'b1, 1'b1, 8'h00);
            if (i == 255) begin
                lit(0, 1, 0, 255); lit(1, 1, 0, 255);
            end
            idle(1);
        end
        repeat (350) rand_frame();
        idle(4);

        run_model(0, 1518);
        run_model(1, 4);

        for (int t = 0; t < n_cyc; t++) begin
            @(negedge clk);
            rst_n      = s_rst[t];
            bus0.rx_dv = s_dv[t];
            bus0.rxd   = s_d[t];
            bus1.rx_dv = s_dv[t];
            bus1.rxd   = s_d[t];
            cyc        = t;
            running    = 1'b1;
        end
        @(posedge clk);
        #2;
        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
